// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter that locks the shared resource to one requester for a whole packet.
// state | meaning: IDLE = no grant, arbitrate next cycle; LOCK = gnt_idx owns the bus until a last-beat transfer
module round_robin_arbiter #(
  parameter  int WIDTH     = 4,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 bus_vld,
  input  logic                 bus_rdy,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_vld
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t               state;
  logic [WIDTH_LOG-1:0] ptr;
  logic [WIDTH_LOG-1:0] sel_idx;
  logic [WIDTH_LOG-1:0] cand;
  logic                 sel_found;
  logic                 xfer_last;

  // First set request at or above ptr; WIDTH is a power of two so the index wraps by truncation.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cand = ptr + WIDTH_LOG'(i);
      if (!sel_found && req_vld[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  // gnt is zero outside LOCK, so both bus-side outputs are naturally quiet in IDLE.
  assign bus_vld   = gnt_vld & req_vld[gnt_idx];
  assign req_rdy   = gnt & {WIDTH{bus_rdy}};
  assign xfer_last = bus_vld & bus_rdy & req_lst[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= LOCK;
            gnt     <= WIDTH'(1) << sel_idx;
            gnt_idx <= sel_idx;
            gnt_vld <= 1'b1;
          end
        end
        LOCK: begin
          if (xfer_last) begin
            state   <= IDLE;
            ptr     <= gnt_idx + WIDTH_LOG'(1);
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: expected grant indices are queued when requests
// are driven and popped when the arbiter raises gnt_vld.
module tb_round_robin_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] req_vld;
  logic [WIDTH-1:0] req_lst;
  logic [WIDTH-1:0] req_rdy;
  logic             bus_vld;
  logic             bus_rdy;
  logic [WIDTH-1:0] gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  round_robin_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_lst (req_lst),
    .req_rdy (req_rdy),
    .bus_vld (bus_vld),
    .bus_rdy (bus_rdy),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt_vld"}, 32'(gnt_vld), 32'd0);
    check({tag, "_gnt"},     32'(gnt),     32'd0);
    check({tag, "_gnt_idx"}, 32'(gnt_idx), 32'd0);
  endtask

  task automatic wait_grant(input string tag, input int exp_lat);
    int lat;
    int exp_idx;
    logic [31:0] exp_gnt;
    lat = 0;
    while (!gnt_vld && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_vld"}, 32'(gnt_vld), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    exp_gnt = (exp_idx >= 0) ? (32'd1 << exp_idx) : 32'd0;
    check({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    check({tag, "_gnt"}, 32'(gnt), exp_gnt);
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    req_lst = '0;
    bus_rdy = 1'b0;
    #1;
    check_idle("rst");
    check("rst_bus_vld", 32'(bus_vld), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // first grant from ptr=0 with requests 1 and 3
    req_vld = 4'b1010;
    exp_q.push_back(1);
    wait_grant("first", 1);
    check("first_bus_vld", 32'(bus_vld), 32'd1);
    check("first_req_rdy", 32'(req_rdy), 32'd0);

    // three-beat packet from owner 1, last on third beat
    req_vld = 4'b1011;
    bus_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req_lst = (b == 2) ? 4'b0010 : 4'b0000;
      #1;
      check("pkt_req_rdy", 32'(req_rdy), 32'b0010);
      check("pkt_bus_vld", 32'(bus_vld), 32'd1);
      check("pkt_held",    32'(gnt_idx), 32'd1);
      tick();
    end
    req_lst = '0;
    check_idle("pkt_release");
    check("pkt_release_rdy", 32'(req_rdy), 32'd0);
    exp_q.push_back(3);
    wait_grant("after_pkt", 1);
    req_lst = 4'b1000;
    tick();
    check_idle("rel3");
    req_vld = '0;
    req_lst = '0;
    tick();
    check_idle("idle_no_req");

    // all ports request single-beat packets: 0,1,2,3,0
    req_vld = 4'b1111;
    req_lst = 4'b1111;
    bus_rdy = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr", 1);
      tick();
      check_idle("rr_gap");
    end
    req_vld = '0;
    req_lst = '0;
    bus_rdy = 1'b0;
    tick();

    // owner 2 stalled by bus_rdy=0; other requests must not disturb ptr
    req_vld = 4'b0100;
    exp_q.push_back(2);
    wait_grant("stall", 1);
    req_vld = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      check("stall_idx", 32'(gnt_idx), 32'd2);
      check("stall_rdy", 32'(req_rdy), 32'd0);
      tick();
    end
    bus_rdy = 1'b1;
    req_lst = 4'b0100;
    #1;
    check("stall_rdy_go", 32'(req_rdy), 32'b0100);
    tick();
    check_idle("stall_release");
    req_lst = '0;
    bus_rdy = 1'b0;
    exp_q.push_back(3);
    wait_grant("ptr3", 1);
    bus_rdy = 1'b1;
    req_lst = 4'b1000;
    tick();
    req_vld = '0;
    req_lst = '0;
    bus_rdy = 1'b0;
    tick();

    // owner 0 drops req_vld mid-packet, grant persists
    req_vld = 4'b0001;
    exp_q.push_back(0);
    wait_grant("gap", 1);
    bus_rdy = 1'b1;
    tick();
    req_vld = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("gap_bus_vld", 32'(bus_vld), 32'd0);
      check("gap_held",    32'(gnt_vld), 32'd1);
      tick();
    end
    req_vld = 4'b0001;
    req_lst = 4'b0001;
    tick();
    check_idle("gap_release");
    req_vld = '0;
    req_lst = '0;
    tick();

    // async reset while owner 3 holds the bus mid-packet
    req_vld = 4'b1000;
    exp_q.push_back(3);
    wait_grant("rst_lock", 1);
    tick();
    check("rst_lock_bus_vld", 32'(bus_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_bus_vld", 32'(bus_vld), 32'd0);
    check("async_rst_req_rdy", 32'(req_rdy), 32'd0);
    #2;
    rst_n   = 1'b1;
    req_vld = 4'b1001;
    exp_q.push_back(0);
    wait_grant("post_rst", 1);
    req_lst = 4'b0001;
    tick();
    check_idle("post_rst_release");
    req_vld = '0;
    req_lst = '0;
    bus_rdy = 1'b0;
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of requesters; legal values 2, 4, 8, 16, 32.
REQ-002 SHALL have localparam WIDTH_LOG, $clog2(WIDTH), grant index width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld  input  WIDTH  per-requester beat valid.
REQ-006 SHALL have port req_lst  input  WIDTH  per-requester last-beat flag, qualified by req_vld.
REQ-007 SHALL have port req_rdy  output  WIDTH  per-requester beat accepted.
REQ-008 SHALL have port bus_vld  output  1  shared-resource beat valid.
REQ-009 SHALL have port bus_rdy  input  1  shared-resource ready.
REQ-010 SHALL have port gnt  output  WIDTH  one-hot grant, registered.
REQ-011 SHALL have port gnt_idx  output  WIDTH_LOG  binary index of gnt, registered.
REQ-012 SHALL have port gnt_vld  output  1  grant active, registered.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and LOCK (one requester owns the resource).
REQ-014 SHALL hold a priority pointer ptr (WIDTH_LOG bits); requester ptr has highest priority, then ptr+1, ... wrapping modulo WIDTH.
REQ-015 In IDLE with req_vld != 0, SHALL select the first set req_vld bit searching upward from ptr with wrap, and on the next edge load gnt/gnt_idx, set gnt_vld=1, enter LOCK (1-cycle arbitration latency).
REQ-016 In IDLE with req_vld == 0, SHALL remain in IDLE with gnt=0, gnt_vld=0, ptr unchanged.
REQ-017 In IDLE, bus_vld and req_rdy SHALL be 0.
REQ-018 In LOCK, bus_vld SHALL equal req_vld[gnt_idx] combinationally; req_rdy[gnt_idx] SHALL equal bus_rdy; all other req_rdy bits SHALL be 0.
REQ-019 A transfer SHALL occur when bus_vld & bus_rdy are both 1.
REQ-020 A transfer with req_lst[gnt_idx]=1 SHALL release the grant: on that edge gnt=0, gnt_vld=0, state IDLE, ptr = gnt_idx+1 modulo WIDTH.
REQ-021 A transfer without last, or the owner deasserting req_vld, SHALL NOT release the grant; ownership persists indefinitely until a last transfer.
REQ-022 Requests from non-owners during LOCK SHALL be ignored and SHALL NOT alter ptr.
REQ-023 After release, at least one IDLE cycle SHALL precede the next grant (no back-to-back grant).
REQ-024 gnt SHALL always be one-hot or zero; gnt_vld SHALL equal |gnt; gnt_idx SHALL equal the encoded gnt when gnt_vld=1 and 0 otherwise.
REQ-025 A single-beat packet (req_lst=1 on first beat) SHALL be legal and release after one transfer.
REQ-026 Arbitration SHALL be starvation-free: any continuously requesting port SHALL be granted within WIDTH-1 intervening grants.

Reset
REQ-027 While rst_n=0, SHALL force state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_vld=0, hence bus_vld=0 and req_rdy=0, asynchronously, with no clock needed.
REQ-028 Reset asserted during LOCK SHALL abort the grant immediately; after deassertion, arbitration SHALL restart from ptr=0 on the first rising edge.

Verification
REQ-029 Reset then req_vld=4'b1010 in IDLE -> next edge gnt=4'b0010, gnt_idx=1, gnt_vld=1; bus_vld=1.
REQ-030 Owner 1 sends 3 beats, lst on 3rd, bus_rdy=1 every cycle while req_vld=4'b1011 -> release after 3rd beat, one IDLE cycle, then gnt_idx=3 (ptr=2, first set from 2 is 3).
REQ-031 All four ports request continuously with single-beat packets -> grant sequence 0,1,2,3,0 with one IDLE cycle between grants.
REQ-032 Owner 2 holds req_vld=1, bus_rdy=0 for 10 cycles -> gnt_idx stays 2, req_rdy=4'b0000, no release; then bus_rdy=1 with lst -> release, ptr=3.
REQ-033 Owner deasserts req_vld mid-packet for 5 cycles -> bus_vld=0, grant held; reasserts with lst and bus_rdy=1 -> release.
REQ-034 rst_n pulled low mid-packet (LOCK, gnt_idx=3) -> gnt, gnt_vld, bus_vld, req_rdy all 0 before next clock edge; after release with req_vld=4'b1001 -> gnt_idx=0.
